// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory controller
// Purpose: FSM state encoding, access-size encodings and alignment helpers
//          shared by dmem_ctrl and mem_align.
// Ports:   none (package).
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // The reserved size code 3 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_WORD : size;
  endfunction

  // Expects a size already passed through norm_size.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~addr_lo[0];
      default:   return (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/address/data-phase bus between controller and memory
// Purpose: groups the data-memory bus signals.
// Ports (master = controller side):
//   req_o, wr_o       request and write strobe
//   size_o, addr_o    access size and byte address
//   wdata_o           lane-replicated store data
//   addr_ok_i         address phase accepted
//   data_ok_i         data phase complete
//   rdata_i           read data, valid with data_ok_i
interface dmem_ctrl_if;

  logic        req_o;
  logic        wr_o;
  logic [1:0]  size_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        addr_ok_i;
  logic        data_ok_i;
  logic [31:0] rdata_i;

  modport master (
    output req_o, wr_o, size_o, addr_o, wdata_o,
    input  addr_ok_i, data_ok_i, rdata_i
  );

  modport slave (
    input  req_o, wr_o, size_o, addr_o, wdata_o,
    output addr_ok_i, data_ok_i, rdata_i
  );

endinterface

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane replication and load lane extraction
// Purpose: purely combinational data steering for byte/half/word accesses.
// Ports:
//   i_size     normalised access size (BYTE/HALF/WORD)
//   i_addr_lo  low address bits selecting the lane
//   i_sign     1 = sign-extend loads, 0 = zero-extend
//   i_wdata    raw store data (low bits significant)
//   i_rdata    raw 32-bit bus read data
//   o_wdata    store data replicated across all lanes
//   o_rdata    extracted and extended load result
module mem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wdata = i_wdata;
    case (i_size)
      SIZE_BYTE: o_wdata = {4{i_wdata[7:0]}};
      SIZE_HALF: o_wdata = {2{i_wdata[15:0]}};
      default:   o_wdata = i_wdata;
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_rdata = i_rdata;
    case (i_size)
      SIZE_BYTE: o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
      SIZE_HALF: o_rdata = {{16{i_sign & w_half[15]}}, w_half};
      default:   o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage data-memory controller with stall generation
// Purpose: turns MEM-stage load/store decodes into request/address/data bus
//          transactions, stalls the pipeline until the access completes and
//          returns the extended load result.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   memread_i, memwrite_i  load / store decode (both set = store)
//   size_i, sign_i         access size, load sign-extension select
//   addr_i, wdata_i        effective address, store data
//   flush_i                MEM-stage instruction cancelled
//   stall_other_i          pipeline held by another source
//   bus                    data-memory bus (master side)
//   rdata_o                extended load result, held until next load
//   stall_o                pipeline stall request
//   adel_o, ades_o         misaligned load / store address errors
module dmem_ctrl
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [1:0]        size_i,
  input  logic              sign_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  input  logic              stall_other_i,
  dmem_ctrl_if.master       bus,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              adel_o,
  output logic              ades_o
);

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_wr;
  logic [31:0] r_wdata;
  logic        r_sign;
  logic        r_discard;
  logic [31:0] r_rdata;

  logic [1:0]  w_size_n;
  logic        w_aligned;
  logic        w_is_store;
  logic        w_is_load;
  logic        w_access;
  logic        w_capture;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rdata_ext;

  assign w_size_n   = norm_size(size_i);
  assign w_aligned  = is_aligned(w_size_n, addr_i[1:0]);
  assign w_is_store = memwrite_i;
  assign w_is_load  = memread_i & ~memwrite_i;
  assign w_access   = (memread_i | memwrite_i) & ~flush_i & w_aligned;

  mem_align u_align (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_sign    (r_sign),
    .i_wdata   (r_wdata),
    .i_rdata   (bus.rdata_i),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_access) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        // Once the address is accepted the bus transaction must run to
        // completion; a flush can only abort before acceptance.
        if (bus.addr_ok_i && bus.data_ok_i) w_next = flush_i ? ST_IDLE : ST_DONE;
        else if (bus.addr_ok_i)             w_next = ST_DATA;
        else if (flush_i)                   w_next = ST_IDLE;
      end
      ST_DATA: begin
        if (bus.data_ok_i) w_next = (r_discard | flush_i) ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (!stall_other_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_o = 1'b0;
    bus.wr_o  = 1'b0;
    stall_o   = 1'b0;
    adel_o    = 1'b0;
    ades_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall_o = w_access;
        adel_o  = w_is_load  & ~w_aligned & ~flush_i;
        ades_o  = w_is_store & ~w_aligned & ~flush_i;
      end
      ST_ADDR: begin
        bus.req_o = 1'b1;
        bus.wr_o  = r_wr;
        stall_o   = 1'b1;
      end
      ST_DATA: begin
        stall_o = 1'b1;
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

  assign bus.size_o  = r_size;
  assign bus.addr_o  = r_addr;
  assign bus.wdata_o = w_wdata_rep;
  assign rdata_o     = r_rdata;

  // Load data is kept only for loads that were not cancelled at any point.
  assign w_capture = bus.data_ok_i & ~r_wr & ~flush_i &
                     (((r_state == ST_ADDR) & bus.addr_ok_i) |
                      ((r_state == ST_DATA) & ~r_discard));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= 32'd0;
      r_size    <= 2'd0;
      r_wr      <= 1'b0;
      r_wdata   <= 32'd0;
      r_sign    <= 1'b0;
      r_discard <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      if ((r_state == ST_IDLE) && w_access) begin
        r_addr  <= addr_i;
        r_size  <= w_size_n;
        r_wr    <= w_is_store;
        r_wdata <= wdata_i;
        r_sign  <= sign_i;
      end

      if (r_state == ST_DATA) begin
        r_discard <= bus.data_ok_i ? 1'b0 : (r_discard | flush_i);
      end else if ((r_state == ST_ADDR) && bus.addr_ok_i && !bus.data_ok_i) begin
        r_discard <= flush_i;
      end else begin
        r_discard <= 1'b0;
      end

      if (w_capture) r_rdata <= w_rdata_ext;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        memread_i;
  logic        memwrite_i;
  logic [1:0]  size_i;
  logic        sign_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        flush_i;
  logic        stall_other_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        adel_o;
  logic        ades_o;

  int total;
  int bad;

  dmem_ctrl_if bif ();

  dmem_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .memread_i     (memread_i),
    .memwrite_i    (memwrite_i),
    .size_i        (size_i),
    .sign_i        (sign_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .flush_i       (flush_i),
    .stall_other_i (stall_other_i),
    .bus           (bif),
    .rdata_o       (rdata_o),
    .stall_o       (stall_o),
    .adel_o        (adel_o),
    .ades_o        (ades_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
    memread_i  = rd;
    memwrite_i = wr;
    size_i     = sz;
    sign_i     = sg;
    addr_i     = a;
    wdata_i    = wd;
  endtask

  task automatic idle_in();
    set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    flush_i = 1'b0;
  endtask

  task automatic bus_idle();
    bif.addr_ok_i = 1'b0;
    bif.data_ok_i = 1'b0;
    bif.rdata_i   = 32'd0;
  endtask

  // Issues a load served with addr_ok and data_ok together; returns in DONE.
  task automatic fast_load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                           input logic [31:0] rd);
    set_req(1'b1, 1'b0, sz, sg, a, 32'd0);
    tick();
    bif.addr_ok_i = 1'b1;
    bif.data_ok_i = 1'b1;
    bif.rdata_i   = rd;
    tick();
    bus_idle();
    #2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    stall_other_i = 1'b0;
    idle_in();
    bus_idle();
    repeat (2) @(posedge clk);
    #3;
    chk("rst_req",   {31'd0, bif.req_o}, 32'd0);
    chk("rst_wr",    {31'd0, bif.wr_o},  32'd0);
    chk("rst_stall", {31'd0, stall_o},   32'd0);
    chk("rst_rdata", rdata_o,            32'd0);
    chk("rst_addr",  bif.addr_o,         32'd0);
    chk("rst_size",  {30'd0, bif.size_o}, 32'd0);
    chk("rst_wdata", bif.wdata_o,        32'd0);

    // LW 0x100, addr_ok then data_ok on separate cycles
    rst = 1'b0;
    tick();
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    #2;
    chk("lw_idle_stall", {31'd0, stall_o}, 32'd1);
    chk("lw_idle_req",   {31'd0, bif.req_o}, 32'd0);
    chk("lw_adel",       {31'd0, adel_o}, 32'd0);
    tick();
    bif.addr_ok_i = 1'b1;
    #2;
    chk("lw_addr_req",   {31'd0, bif.req_o}, 32'd1);
    chk("lw_addr_addr",  bif.addr_o, 32'h100);
    chk("lw_addr_size",  {30'd0, bif.size_o}, 32'd2);
    chk("lw_addr_wr",    {31'd0, bif.wr_o}, 32'd0);
    chk("lw_addr_stall", {31'd0, stall_o}, 32'd1);
    tick();
    bif.addr_ok_i = 1'b0;
    bif.data_ok_i = 1'b1;
    bif.rdata_i   = 32'hDEADBEEF;
    #2;
    chk("lw_data_req",   {31'd0, bif.req_o}, 32'd0);
    chk("lw_data_stall", {31'd0, stall_o}, 32'd1);
    tick();
    bus_idle();
    #2;
    chk("lw_done_stall", {31'd0, stall_o}, 32'd0);
    chk("lw_rdata",      rdata_o, 32'hDEADBEEF);
    tick();
    idle_in();
    #2;
    chk("lw_after_stall", {31'd0, stall_o}, 32'd0);
    chk("lw_after_rdata", rdata_o, 32'hDEADBEEF);

    // LB 0x103 sign-extended, DONE held by stall_other_i
    fast_load(2'd0, 1'b1, 32'h103, 32'h80112233);
    stall_other_i = 1'b1;
    chk("lb_rdata", rdata_o, 32'hFFFFFF80);
    chk("lb_done_stall", {31'd0, stall_o}, 32'd0);
    tick();
    #2;
    chk("lb_hold_req",   {31'd0, bif.req_o}, 32'd0);
    chk("lb_hold_stall", {31'd0, stall_o}, 32'd0);
    chk("lb_hold_rdata", rdata_o, 32'hFFFFFF80);
    stall_other_i = 1'b0;
    tick();
    idle_in();

    // LBU 0x103 zero-extended
    fast_load(2'd0, 1'b0, 32'h103, 32'h80112233);
    chk("lbu_rdata", rdata_o, 32'h00000080);
    tick();
    idle_in();

    // LH 0x102 sign-extended upper half
    fast_load(2'd1, 1'b1, 32'h102, 32'h80112233);
    chk("lh_rdata", rdata_o, 32'hFFFF8011);
    tick();
    idle_in();

    // SH 0x202 with two address-phase wait cycles
    set_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD);
    #2;
    chk("sh_ades", {31'd0, ades_o}, 32'd0);
    chk("sh_idle_stall", {31'd0, stall_o}, 32'd1);
    tick();
    #2;
    chk("sh_w1_req",   {31'd0, bif.req_o}, 32'd1);
    chk("sh_w1_wr",    {31'd0, bif.wr_o}, 32'd1);
    chk("sh_w1_size",  {30'd0, bif.size_o}, 32'd1);
    chk("sh_w1_wdata", bif.wdata_o, 32'hABCDABCD);
    chk("sh_w1_addr",  bif.addr_o, 32'h202);
    tick();
    #2;
    chk("sh_w2_req",   {31'd0, bif.req_o}, 32'd1);
    chk("sh_w2_wdata", bif.wdata_o, 32'hABCDABCD);
    tick();
    bif.addr_ok_i = 1'b1;
    #2;
    chk("sh_acc_req", {31'd0, bif.req_o}, 32'd1);
    tick();
    bif.addr_ok_i = 1'b0;
    bif.data_ok_i = 1'b1;
    #2;
    chk("sh_data_req",   {31'd0, bif.req_o}, 32'd0);
    chk("sh_data_stall", {31'd0, stall_o}, 32'd1);
    tick();
    bus_idle();
    #2;
    chk("sh_done_stall", {31'd0, stall_o}, 32'd0);
    chk("sh_rdata_kept", rdata_o, 32'hFFFF8011);
    tick();
    idle_in();

    // Misaligned accesses
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'd0);
    #2;
    chk("mis_lw_adel",  {31'd0, adel_o}, 32'd1);
    chk("mis_lw_ades",  {31'd0, ades_o}, 32'd0);
    chk("mis_lw_req",   {31'd0, bif.req_o}, 32'd0);
    chk("mis_lw_stall", {31'd0, stall_o}, 32'd0);
    tick();
    #2;
    chk("mis_lw_req2",  {31'd0, bif.req_o}, 32'd0);
    set_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h201, 32'd0);
    #1;
    chk("mis_sh_ades",  {31'd0, ades_o}, 32'd1);
    chk("mis_sh_adel",  {31'd0, adel_o}, 32'd0);
    chk("mis_sh_stall", {31'd0, stall_o}, 32'd0);
    set_req(1'b1, 1'b0, 2'd3, 1'b0, 32'h102, 32'd0);
    #1;
    chk("mis_sz3_adel", {31'd0, adel_o}, 32'd1);
    idle_in();
    tick();

    // Flush while in DATA: transaction completes, result discarded
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
    tick();
    bif.addr_ok_i = 1'b1;
    tick();
    bif.addr_ok_i = 1'b0;
    flush_i = 1'b1;
    #2;
    chk("fl_data_stall", {31'd0, stall_o}, 32'd1);
    tick();
    flush_i = 1'b0;
    bif.data_ok_i = 1'b1;
    bif.rdata_i   = 32'h55555555;
    #2;
    chk("fl_data_stall2", {31'd0, stall_o}, 32'd1);
    tick();
    bus_idle();
    // memread&memwrite byte store: stall here proves FSM returned to IDLE
    set_req(1'b1, 1'b1, 2'd0, 1'b0, 32'h401, 32'h000000A5);
    #2;
    chk("fl_rdata_kept", rdata_o, 32'hFFFF8011);
    chk("fl_to_idle",    {31'd0, stall_o}, 32'd1);
    tick();
    #2;
    chk("rw_wr",    {31'd0, bif.wr_o}, 32'd1);
    chk("rw_wdata", bif.wdata_o, 32'hA5A5A5A5);
    chk("rw_size",  {30'd0, bif.size_o}, 32'd0);
    chk("rw_req",   {31'd0, bif.req_o}, 32'd1);
    flush_i = 1'b1;
    tick();
    idle_in();
    #2;
    chk("fa_req",   {31'd0, bif.req_o}, 32'd0);
    chk("fa_stall", {31'd0, stall_o}, 32'd0);

    // Reset while in ADDR
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'd0);
    tick();
    #2;
    chk("ra_req", {31'd0, bif.req_o}, 32'd1);
    chk("ra_addr", bif.addr_o, 32'h500);
    rst = 1'b1;
    idle_in();
    #1;
    chk("ra_rst_req",   {31'd0, bif.req_o}, 32'd0);
    chk("ra_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("ra_rst_addr",  bif.addr_o, 32'd0);
    chk("ra_rst_rdata", rdata_o, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    #2;
    chk("ra_post_req", {31'd0, bif.req_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
